// File: rtl/decryption_demux_pkg.sv
// decryption_demux_pkg
// Shared definitions for the decryption input router: FSM state encoding,
// channel tag encoding carried alongside each buffered byte, and the default
// end-of-message byte.
package decryption_demux_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStream,
        StDiscard,
        StWaitAck,
        StWaitDone
    } state_e;

    localparam logic [1:0] CH_CAESAR  = 2'd0;
    localparam logic [1:0] CH_SCYTALE = 2'd1;
    localparam logic [1:0] CH_ZIGZAG  = 2'd2;
    localparam logic [1:0] CH_INVALID = 2'd3;

    localparam logic [7:0] DEF_TERMINATOR = 8'hFA;

endpackage

// File: rtl/decryption_demux_if.sv
// decryption_demux_if
// Bundles the router's data-side signals.
//   data_i/valid_i/select      : encrypted byte stream and its channel select
//   dataN_o/validN_o (N=0..2)  : per-decryptor output channels
//   busyN_i (N=0..2)           : per-decryptor busy
//   busy_o/overflow_o/err_o    : router status
// The slave modport is the router side; master is the environment side.
interface decryption_demux_if #(
    parameter int unsigned D_WIDTH = 8
) ();

    logic [D_WIDTH-1:0] data_i;
    logic               valid_i;
    logic [1:0]         select;

    logic [D_WIDTH-1:0] data0_o;
    logic [D_WIDTH-1:0] data1_o;
    logic [D_WIDTH-1:0] data2_o;
    logic               valid0_o;
    logic               valid1_o;
    logic               valid2_o;

    logic               busy0_i;
    logic               busy1_i;
    logic               busy2_i;

    logic               busy_o;
    logic               overflow_o;
    logic               err_o;

    modport slave (
        input  data_i, valid_i, select, busy0_i, busy1_i, busy2_i,
        output data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o,
        output busy_o, overflow_o, err_o
    );

    modport master (
        output data_i, valid_i, select, busy0_i, busy1_i, busy2_i,
        input  data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o,
        input  busy_o, overflow_o, err_o
    );

endinterface

// File: rtl/demux_fifo.sv
// demux_fifo
// Single-clock synchronous FIFO with first-word fall-through: rdata_o always
// shows the head entry while empty_o is low.
//   clk, rst         : clock, synchronous active-high reset (flushes pointers)
//   push_i, wdata_i  : write request and data (ignored when full without pop)
//   pop_i            : remove head (ignored when empty)
//   rdata_o          : head entry
//   full_o, empty_o  : status
module demux_fifo #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/decryption_demux.sv
// decryption_demux
// Front-end router: buffers the encrypted byte stream tagged with its select
// value and steers each whole message (up to and including the terminator)
// to the Caesar, Scytale or ZigZag decryptor, then waits for that decryptor
// to take and finish the message before starting the next one.
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : data stream in, three channel outputs, decryptor busy inputs,
//              busy_o / overflow_o (sticky) / err_o (one-cycle pulse)
module decryption_demux
    import decryption_demux_pkg::*;
#(
    parameter int unsigned        D_WIDTH     = 8,
    parameter int unsigned        FIFO_DEPTH  = 16,
    parameter logic [D_WIDTH-1:0] TERMINATOR  = DEF_TERMINATOR,
    parameter int unsigned        ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    decryption_demux_if.slave    bus_io
);

    localparam int unsigned EW    = D_WIDTH + 2;
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_e                       state_q, state_d;
    logic [1:0]                   chan_q, chan_d;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic [2:0]                   valid_q, valid_d;
    logic [2:0][D_WIDTH-1:0]      data_q, data_d;
    logic                         err_q, err_d;
    logic                         overflow_q, overflow_d;

    logic [EW-1:0]                head;
    logic [1:0]                   head_tag;
    logic [D_WIDTH-1:0]           head_data;
    logic                         head_term;
    logic                         fifo_full, fifo_empty, pop;
    logic                         emit;
    logic [1:0]                   emit_ch;
    logic [3:0]                   busy_vec;
    logic                         chan_busy;

    demux_fifo #(
        .Width (EW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus_io.valid_i),
        .wdata_i ({bus_io.select, bus_io.data_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_tag  = head[EW-1 -: 2];
    assign head_data = head[D_WIDTH-1:0];
    assign head_term = (head_data == TERMINATOR);

    // The invalid-channel slot never reports busy.
    always_comb begin
        busy_vec             = '0;
        busy_vec[CH_CAESAR]  = bus_io.busy0_i;
        busy_vec[CH_SCYTALE] = bus_io.busy1_i;
        busy_vec[CH_ZIGZAG]  = bus_io.busy2_i;
    end
    assign chan_busy = busy_vec[chan_q];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; the timeout counter is zero everywhere outside
    // WAIT_ACK so it always starts from zero on entry.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    if (head_tag == CH_INVALID) state_d = head_term ? StIdle : StDiscard;
                    else                        state_d = head_term ? StWaitAck : StStream;
                end
            end
            StStream:  if (!fifo_empty && head_term) state_d = StWaitAck;
            StDiscard: if (!fifo_empty && head_term) state_d = StIdle;
            StWaitAck: begin
                if (chan_busy)              state_d = StWaitDone;
                else if (tmo_q == TMO_LAST) state_d = StIdle;
                else                        tmo_d   = tmo_q + 1'b1;
            end
            StWaitDone: if (!chan_busy) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output / datapath logic. The channel is taken from the first byte's tag
    // only; later tags in the same message are ignored.
    always_comb begin
        pop     = 1'b0;
        emit    = 1'b0;
        emit_ch = chan_q;
        chan_d  = chan_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    chan_d = head_tag;
                    if (head_tag == CH_INVALID) begin
                        err_d = 1'b1;
                    end else begin
                        emit    = 1'b1;
                        emit_ch = head_tag;
                    end
                end
            end
            StStream: begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    emit = 1'b1;
                end
            end
            StDiscard: pop = !fifo_empty;
            default:   pop = 1'b0;
        endcase

        for (int k = 0; k < 3; k++) begin
            valid_d[k] = emit && (emit_ch == 2'(k));
            data_d[k]  = valid_d[k] ? head_data : '0;
        end

        overflow_d = overflow_q | (bus_io.valid_i & fifo_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q     <= CH_CAESAR;
            tmo_q      <= '0;
            valid_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            chan_q     <= chan_d;
            tmo_q      <= tmo_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_q      <= err_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus_io.data0_o    = data_q[CH_CAESAR];
    assign bus_io.data1_o    = data_q[CH_SCYTALE];
    assign bus_io.data2_o    = data_q[CH_ZIGZAG];
    assign bus_io.valid0_o   = valid_q[CH_CAESAR];
    assign bus_io.valid1_o   = valid_q[CH_SCYTALE];
    assign bus_io.valid2_o   = valid_q[CH_ZIGZAG];
    assign bus_io.err_o      = err_q;
    assign bus_io.overflow_o = overflow_q;
    assign bus_io.busy_o     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_decryption_demux.sv
module tb_decryption_demux;

    localparam logic [7:0] TERM = 8'hFA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decryption_demux_if #(.D_WIDTH(8)) bus ();

    decryption_demux #(
        .D_WIDTH     (8),
        .FIFO_DEPTH  (16),
        .TERMINATOR  (8'hFA),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] s;
        logic [2:0] busy;
        logic [2:0] ev;
        logic [7:0] ed;
        logic       eb;
        logic       ee;
    } vec_t;

    vec_t       tbl[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q0[$], q1[$], q2[$], want[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic v, logic [7:0] d, logic [1:0] s, logic [2:0] b,
                                logic [2:0] ev, logic [7:0] ed, logic eb, logic ee);
        vec_t r;
        r.v = v; r.d = d; r.s = s; r.busy = b;
        r.ev = ev; r.ed = ed; r.eb = eb; r.ee = ee;
        return r;
    endfunction

    function automatic logic [28:0] obs();
        return {bus.valid2_o, bus.valid1_o, bus.valid0_o,
                bus.data2_o, bus.data1_o, bus.data0_o, bus.busy_o, bus.err_o};
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.select  = s;
    endtask

    // One clock; sample #1 after the edge and log every forwarded byte.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.valid0_o) q0.push_back(bus.data0_o);
        if (bus.valid1_o) q1.push_back(bus.data1_o);
        if (bus.valid2_o) q2.push_back(bus.data2_o);
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); q2.delete();
    endtask

    task automatic check_chan(input int ch, input string name);
        logic [7:0] g[$];
        case (ch)
            0:       g = q0;
            1:       g = q1;
            default: g = q2;
        endcase
        check({name, " len"}, 64'(g.size()), 64'(want.size()));
        for (int i = 0; i < g.size() && i < want.size(); i++)
            check($sformatf("%s byte%0d", name, i), 64'(g[i]), 64'(want[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [28:0] exp_vec;
        int          stall_hits;

        // Single Caesar message, busy0 pulsed three cycles after the terminator.
        tbl.push_back(mk(1, 8'h41, 0, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(1, 8'h42, 0, 3'b000, 3'b001, 8'h41, 1, 0));
        tbl.push_back(mk(1, TERM,  0, 3'b000, 3'b001, 8'h42, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b001, TERM,  1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b001, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b001, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b001, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b000, 8'h00, 0, 0));
        // Invalid select message, then a normal Caesar message.
        tbl.push_back(mk(1, 8'h55, 3, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(1, 8'h66, 3, 3'b000, 3'b000, 8'h00, 1, 1));
        tbl.push_back(mk(1, TERM,  3, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(1, 8'h10, 0, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(1, TERM,  0, 3'b000, 3'b001, 8'h10, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b001, TERM,  1, 0));
        // busy0 never rises (busy1 noise ignored); ZigZag message queued meanwhile.
        tbl.push_back(mk(0, 8'h00, 0, 3'b010, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b010, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(1, 8'h77, 2, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(1, TERM,  2, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b100, 8'h77, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b100, TERM,  1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b100, 3'b000, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'b000, 3'b000, 8'h00, 0, 0));

        drive(0, 8'h00, 0);
        bus.busy0_i = 0; bus.busy1_i = 0; bus.busy2_i = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 64'(obs()), 64'd0);
        check("reset overflow", 64'(bus.overflow_o), 64'd0);
        rst = 0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].s);
            {bus.busy2_i, bus.busy1_i, bus.busy0_i} = tbl[i].busy;
            cyc();
            exp_vec = {tbl[i].ev,
                       tbl[i].ev[2] ? tbl[i].ed : 8'h00,
                       tbl[i].ev[1] ? tbl[i].ed : 8'h00,
                       tbl[i].ev[0] ? tbl[i].ed : 8'h00,
                       tbl[i].eb, tbl[i].ee};
            check($sformatf("vec%0d", i), 64'(obs()), 64'(exp_vec));
        end

        // Second message buffered while Scytale decryptor stays busy.
        clear_q();
        stall_hits = 0;
        drive(1, 8'h61, 1); cyc();
        drive(1, 8'h62, 1); cyc();
        drive(1, TERM, 1);  cyc();
        drive(1, 8'h63, 2); cyc();
        bus.busy1_i = 1;
        drive(1, 8'h64, 2); cyc();
        if (bus.valid2_o) stall_hits++;
        drive(1, TERM, 2);  cyc();
        if (bus.valid2_o) stall_hits++;
        drive(0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.valid2_o) stall_hits++;
        end
        check("B ch2 quiet while busy1", 64'(stall_hits), 64'd0);
        bus.busy1_i = 0;
        cyc();
        check("B idle edge", 64'(bus.valid2_o), 64'd0);
        cyc();
        check("B first byte", 64'({bus.valid2_o, bus.data2_o}), 64'({1'b1, 8'h63}));
        repeat (12) cyc();
        want = '{8'h61, 8'h62, TERM};
        check_chan(1, "B ch1");
        want = '{8'h63, 8'h64, TERM};
        check_chan(2, "B ch2");
        want = '{};
        check_chan(0, "B ch0");
        check("B busy_o idle", 64'(bus.busy_o), 64'd0);

        // 20 bytes while stalled in WAIT_DONE: 16 kept, 4 dropped.
        clear_q();
        drive(1, TERM, 0); cyc();
        drive(0, 8'h00, 0); cyc();
        bus.busy0_i = 1; cyc();
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(i), 0);
            cyc();
            if (i == 15) check("C no overflow at 16", 64'(bus.overflow_o), 64'd0);
            if (i == 16) check("C overflow on 17th", 64'(bus.overflow_o), 64'd1);
        end
        drive(0, 8'h00, 0);
        check("C busy_o while stalled", 64'(bus.busy_o), 64'd1);
        bus.busy0_i = 0;
        repeat (18) cyc();
        drive(1, TERM, 0); cyc();
        drive(0, 8'h00, 0);
        repeat (12) cyc();
        check("C overflow sticky", 64'(bus.overflow_o), 64'd1);
        want = '{};
        want.push_back(TERM);
        for (int i = 0; i < 16; i++) want.push_back(8'(i));
        want.push_back(TERM);
        check_chan(0, "C ch0");
        rst = 1; cyc(); rst = 0;
        check("C overflow cleared", 64'(bus.overflow_o), 64'd0);

        // Reset mid-STREAM with 5 bytes still buffered.
        clear_q();
        drive(1, TERM, 0); cyc();
        drive(0, 8'h00, 0); cyc();
        bus.busy0_i = 1; cyc();
        for (int i = 0; i < 7; i++) begin
            drive(1, 8'h31 + 8'(i), 1);
            cyc();
        end
        drive(0, 8'h00, 0);
        bus.busy0_i = 0;
        cyc(); cyc(); cyc();
        check("D streaming", 64'({bus.valid1_o, bus.data1_o}), 64'({1'b1, 8'h32}));
        rst = 1; cyc(); rst = 0;
        check("D outputs zero after rst", 64'(obs()), 64'd0);
        check("D overflow after rst", 64'(bus.overflow_o), 64'd0);
        clear_q();
        drive(1, 8'h21, 2); cyc();
        drive(1, TERM, 2);  cyc();
        check("D first byte latency", 64'({bus.valid2_o, bus.data2_o}), 64'({1'b1, 8'h21}));
        drive(0, 8'h00, 0);
        repeat (12) cyc();
        want = '{};
        check_chan(1, "D ch1 stale");
        want = '{8'h21, TERM};
        check_chan(2, "D ch2");
        check("D busy_o idle", 64'(bus.busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
